// File: rtl/nac_pkg.sv
// Shared opcode, source-select and decode definitions for the next-address controller.
// The decode is a pure function of opcode, test condition and counter-zero.
package nac_pkg;

  typedef enum logic [3:0] {
    OpJz   = 4'h0,
    OpCjs  = 4'h1,
    OpJmap = 4'h2,
    OpCjp  = 4'h3,
    OpPush = 4'h4,
    OpJsrp = 4'h5,
    OpCjv  = 4'h6,
    OpJrp  = 4'h7,
    OpRfct = 4'h8,
    OpRpct = 4'h9,
    OpCrtn = 4'hA,
    OpCjpp = 4'hB,
    OpLdct = 4'hC,
    OpLoop = 4'hD,
    OpCont = 4'hE,
    OpTwb  = 4'hF
  } nac_op_e;

  localparam logic [1:0] SrcUpc = 2'b00;
  localparam logic [1:0] SrcAr  = 2'b01;
  localparam logic [1:0] SrcStk = 2'b10;
  localparam logic [1:0] SrcD   = 2'b11;

  typedef enum logic [1:0] {
    StkNone = 2'b00,
    StkPush = 2'b01,
    StkPop  = 2'b10
  } stk_op_e;

  typedef struct packed {
    logic [1:0] src;
    stk_op_e    stk;
    logic       zero_n;
    logic       map_n;
    logic       vect_n;
    logic       cnt_load;
    logic       cnt_dec;
  } nac_ctrl_t;

  function automatic nac_ctrl_t nac_decode(nac_op_e op, logic cc, logic cnt_zero);
    nac_ctrl_t c;
    c        = '0;
    c.src    = SrcUpc;
    c.stk    = StkNone;
    c.zero_n = 1'b1;
    c.map_n  = 1'b1;
    c.vect_n = 1'b1;
    unique case (op)
      OpJz:   c.zero_n = 1'b0;
      OpCjs:  if (cc) begin
        c.src = SrcD;
        c.stk = StkPush;
      end
      OpJmap: begin
        c.src   = SrcD;
        c.map_n = 1'b0;
      end
      OpCjp:  if (cc) c.src = SrcD;
      OpPush: begin
        c.stk      = StkPush;
        c.cnt_load = cc;
      end
      OpJsrp: begin
        c.src = cc ? SrcD : SrcAr;
        c.stk = StkPush;
      end
      OpCjv:  begin
        c.src    = cc ? SrcD : SrcUpc;
        c.vect_n = 1'b0;
      end
      OpJrp:  c.src = cc ? SrcD : SrcAr;
      OpRfct: if (!cnt_zero) begin
        c.src     = SrcStk;
        c.cnt_dec = 1'b1;
      end else begin
        c.stk = StkPop;
      end
      OpRpct: if (!cnt_zero) begin
        c.src     = SrcD;
        c.cnt_dec = 1'b1;
      end
      OpCrtn: if (cc) begin
        c.src = SrcStk;
        c.stk = StkPop;
      end
      OpCjpp: if (cc) begin
        c.src = SrcD;
        c.stk = StkPop;
      end
      OpLdct: c.cnt_load = 1'b1;
      OpLoop: if (cc) c.stk = StkPop;
              else    c.src = SrcStk;
      OpCont: c.src = SrcUpc;
      OpTwb:  if (cc) begin
        c.src = SrcD;
        c.stk = StkPop;
      end else if (!cnt_zero) begin
        c.src     = SrcStk;
        c.cnt_dec = 1'b1;
      end else begin
        c.stk = StkPop;
      end
      default: c.src = SrcUpc;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/loop_counter.sv
// Unsigned loop down-counter with parallel load; decrement saturates at zero.
module loop_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/next_address_ctrl.sv
// Next-address controller: registered opcode, combinational sequencer control decode,
// loop counter and (with STACK_CHECK_EN defined) a stack occupancy / error tracker.
module next_address_ctrl
  import nac_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned STK_DEPTH = 4
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic [3:0]       I,
  input  logic             EN,
  input  logic             CC,
  input  logic [CNT_W-1:0] CNT_D,
  output logic [1:0]       S,
  output logic             FE,
  output logic             PUP,
  output logic             ZERO,
  output logic             MAP_E,
  output logic             VECT_E,
  output logic             PL_E,
  output logic             CNT_ZERO,
  output logic             STK_ERR,
  output logic [2:0]       DEPTH
);

  if ((STK_DEPTH < 1) || (STK_DEPTH > 7)) begin : gen_bad_depth
    $error("STK_DEPTH must fit the 3-bit DEPTH output (1..7)");
  end

  nac_op_e   ir_q, ir_d;
  nac_ctrl_t ctrl;
  logic      cnt_zero;

  // Holding IR re-executes it every cycle, side effects included.
  always_comb begin
    ir_d = ir_q;
    if (EN) begin
      ir_d = nac_op_e'(I);
    end
  end

  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      ir_q <= OpJz;
    end else begin
      ir_q <= ir_d;
    end
  end

  always_comb begin
    ctrl = nac_decode(ir_q, CC, cnt_zero);
  end

  loop_counter #(
    .Width (CNT_W)
  ) u_loop_counter (
    .clk_i      (CP),
    .rst_ni     (CLR),
    .load_i     (ctrl.cnt_load),
    .dec_i      (ctrl.cnt_dec),
    .load_val_i (CNT_D),
    .zero_o     (cnt_zero)
  );

  assign S        = ctrl.src;
  assign FE       = (ctrl.stk == StkNone);
  assign PUP      = (ctrl.stk == StkPush);
  assign ZERO     = ctrl.zero_n;
  assign MAP_E    = ctrl.map_n;
  assign VECT_E   = ctrl.vect_n;
  assign PL_E     = ~((ctrl.src == SrcD) && ctrl.map_n && ctrl.vect_n);
  assign CNT_ZERO = cnt_zero;

`ifdef STACK_CHECK_EN
  localparam logic [2:0] DepthMax = 3'(STK_DEPTH);

  logic [2:0] depth_q, depth_d;
  logic       err_q, err_d;

  // Out-of-range push/pop leaves DEPTH saturated and latches the error.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (ir_q == OpJz) begin
      depth_d = '0;
      err_d   = 1'b0;
    end else if (ctrl.stk == StkPush) begin
      if (depth_q == DepthMax) begin
        err_d = 1'b1;
      end else begin
        depth_d = depth_q + 3'd1;
      end
    end else if (ctrl.stk == StkPop) begin
      if (depth_q == '0) begin
        err_d = 1'b1;
      end else begin
        depth_d = depth_q - 3'd1;
      end
    end
  end

  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign DEPTH   = depth_q;
  assign STK_ERR = err_q;
`else
  assign DEPTH   = '0;
  assign STK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_next_address_ctrl.sv
// Self-checking bench for next_address_ctrl: directed scenarios then randomized opcodes,
// all compared against a behavioural model of the opcode table.
module tb_next_address_ctrl;

  localparam int CntW     = 8;
  localparam int StkDepth = 4;
`ifdef STACK_CHECK_EN
  localparam bit StkChk = 1'b1;
`else
  localparam bit StkChk = 1'b0;
`endif

  localparam int JZ = 0, CJS = 1, JMAP = 2, CJP = 3, PUSH = 4, JSRP = 5, CJV = 6, JRP = 7;
  localparam int RFCT = 8, RPCT = 9, CRTN = 10, CJPP = 11, LDCT = 12, LOOP = 13, CONT = 14;
  localparam int TWB = 15;
  localparam int ActNone = 0, ActPush = 1, ActPop = 2;

  logic            CP = 1'b0;
  logic            CLR = 1'b0;
  logic [3:0]      I = 4'h0;
  logic            EN = 1'b0;
  logic            CC = 1'b0;
  logic [CntW-1:0] CNT_D = '0;
  logic [1:0]      S;
  logic            FE, PUP, ZERO, MAP_E, VECT_E, PL_E, CNT_ZERO, STK_ERR;
  logic [2:0]      DEPTH;

  next_address_ctrl #(
    .CNT_W     (CntW),
    .STK_DEPTH (StkDepth)
  ) dut (
    .CP       (CP),
    .CLR      (CLR),
    .I        (I),
    .EN       (EN),
    .CC       (CC),
    .CNT_D    (CNT_D),
    .S        (S),
    .FE       (FE),
    .PUP      (PUP),
    .ZERO     (ZERO),
    .MAP_E    (MAP_E),
    .VECT_E   (VECT_E),
    .PL_E     (PL_E),
    .CNT_ZERO (CNT_ZERO),
    .STK_ERR  (STK_ERR),
    .DEPTH    (DEPTH)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_ir = 0;
  int m_cnt = 0;
  int m_depth = 0;
  bit m_err = 1'b0;

  typedef struct {
    int src;
    int act;
    bit zero_n;
    bit map_n;
    bit vect_n;
  } rule_t;

  // Opcode table as written in the datasheet.
  function automatic rule_t rule(int op, bit cc, int cnt);
    rule_t r;
    bit    nz = (cnt != 0);
    r = '{src: 0, act: ActNone, zero_n: 1'b1, map_n: 1'b1, vect_n: 1'b1};
    case (op)
      JZ:   r.zero_n = 1'b0;
      CJS:  if (cc) begin r.src = 3; r.act = ActPush; end
      JMAP: begin r.src = 3; r.map_n = 1'b0; end
      CJP:  r.src = cc ? 3 : 0;
      PUSH: r.act = ActPush;
      JSRP: begin r.src = cc ? 3 : 1; r.act = ActPush; end
      CJV:  begin r.src = cc ? 3 : 0; r.vect_n = 1'b0; end
      JRP:  r.src = cc ? 3 : 1;
      RFCT: if (nz) r.src = 2; else r.act = ActPop;
      RPCT: r.src = nz ? 3 : 0;
      CRTN: if (cc) begin r.src = 2; r.act = ActPop; end
      CJPP: if (cc) begin r.src = 3; r.act = ActPop; end
      LOOP: if (cc) r.act = ActPop; else r.src = 2;
      TWB:  if (cc) begin r.src = 3; r.act = ActPop; end
            else if (nz) r.src = 2;
            else r.act = ActPop;
      default: r.src = 0;
    endcase
    return r;
  endfunction

  function automatic logic [12:0] observed();
    return {S, FE, PUP, ZERO, MAP_E, VECT_E, PL_E, CNT_ZERO, STK_ERR, DEPTH};
  endfunction

  function automatic logic [12:0] expected();
    rule_t r = rule(m_ir, CC, m_cnt);
    bit    pl_n = !((r.src == 3) && r.map_n && r.vect_n);
    return {r.src[1:0], r.act == ActNone, r.act == ActPush, r.zero_n, r.map_n, r.vect_n,
            pl_n, m_cnt == 0, m_err, m_depth[2:0]};
  endfunction

  task automatic check(string tag, logic [12:0] obs, logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check(tag, observed(), expected());
  endtask

  task automatic drive(int op, bit en, bit cc, int cntd);
    I     = op[3:0];
    EN    = en;
    CC    = cc;
    CNT_D = cntd[CntW-1:0];
    #2;
  endtask

  // Advance one clock and apply the executing opcode's effects to the model.
  task automatic tick();
    rule_t r   = rule(m_ir, CC, m_cnt);
    bit    cc0 = CC;
    bit    en0 = EN;
    int    i0  = int'(I);
    int    d0  = int'(CNT_D);
    @(posedge CP);
    case (m_ir)
      PUSH: if (cc0) m_cnt = d0;
      LDCT: m_cnt = d0;
      RFCT, RPCT: if (m_cnt != 0) m_cnt = m_cnt - 1;
      TWB:  if (!cc0 && m_cnt != 0) m_cnt = m_cnt - 1;
      default: m_cnt = m_cnt;
    endcase
    if (StkChk) begin
      if (m_ir == JZ) begin
        m_depth = 0;
        m_err   = 1'b0;
      end else if (r.act == ActPush) begin
        if (m_depth == StkDepth) m_err = 1'b1;
        else m_depth = m_depth + 1;
      end else if (r.act == ActPop) begin
        if (m_depth == 0) m_err = 1'b1;
        else m_depth = m_depth - 1;
      end
    end
    if (en0) m_ir = i0;
    #1;
  endtask

  task automatic do_reset(string tag);
    CLR = 1'b0;
    #1;
    m_ir    = JZ;
    m_cnt   = 0;
    m_depth = 0;
    m_err   = 1'b0;
    check_model(tag);
    check({tag, "_fixed"}, {8'b0, S, ZERO, FE, CNT_ZERO}, {8'b0, 2'b00, 1'b0, 1'b1, 1'b1});
    check({tag, "_depth"}, {10'b0, DEPTH}, 13'd0);
    @(posedge CP);
    #1;
    check_model({tag, "_held"});
    CLR = 1'b1;
  endtask

  initial begin
    #1;
    do_reset("reset");

    // LDCT 3, then RPCT held: three S=11 cycles then fall-through.
    drive(LDCT, 1, 0, 0); check_model("ldct_load"); tick();
    drive(RPCT, 1, 0, 3); check_model("ldct_exec"); tick();
    for (int k = 0; k < 3; k++) begin
      drive(CONT, 0, 0, 0); check_model("rpct_loop");
      check("rpct_s", {11'b0, S}, {11'b0, 2'b11});
      tick();
    end
    drive(CONT, 0, 0, 0); check_model("rpct_done");
    check("rpct_exit", {10'b0, S, CNT_ZERO}, {10'b0, 2'b00, 1'b1});
    tick();

    // CJS pass then CRTN pass.
    drive(CJS, 1, 1, 0); check_model("cjs_load"); tick();
    drive(CRTN, 1, 1, 0); check_model("cjs_exec");
    check("cjs_ctl", {9'b0, S, FE, PUP}, {9'b0, 2'b11, 1'b0, 1'b1});
    tick();
    drive(CONT, 1, 1, 0); check_model("crtn_exec");
    check("crtn_ctl", {9'b0, S, FE, PUP}, {9'b0, 2'b10, 1'b0, 1'b0});
    tick();
    drive(CONT, 1, 0, 0); check_model("after_crtn"); tick();

    // Five pushes from empty, then JZ clears.
    drive(JZ, 1, 0, 0); tick();
    drive(PUSH, 1, 0, 0); check_model("jz_before_push"); tick();
    for (int k = 0; k < 5; k++) begin
      drive(PUSH, 0, 0, 0); check_model("push_run"); tick();
    end
    drive(JZ, 1, 0, 0); check_model("push_over"); tick();
    drive(CONT, 1, 0, 0); check_model("jz_exec"); tick();
    drive(CONT, 1, 0, 0); check_model("jz_cleared");
    check("jz_clear", {9'b0, STK_ERR, DEPTH}, 13'd0);
    tick();

    // JMAP and CJV fail.
    drive(JMAP, 1, 0, 0); tick();
    drive(CJV, 1, 0, 0); check_model("jmap");
    check("jmap_ctl", {9'b0, S, MAP_E, PL_E}, {9'b0, 2'b11, 1'b0, 1'b1});
    tick();
    drive(CONT, 1, 0, 0); check_model("cjv_fail");
    check("cjv_ctl", {10'b0, S, VECT_E}, {10'b0, 2'b00, 1'b0});
    tick();

    // TWB counting out with CC=0, then TWB with CC=1.
    drive(LDCT, 1, 0, 0); tick();
    drive(TWB, 1, 0, 2); tick();
    for (int k = 0; k < 2; k++) begin
      drive(CONT, 0, 0, 0); check_model("twb_count");
      check("twb_s", {11'b0, S}, {11'b0, 2'b10});
      tick();
    end
    drive(CONT, 0, 0, 0); check_model("twb_end");
    check("twb_end_ctl", {9'b0, S, FE, PUP}, {9'b0, 2'b00, 1'b0, 1'b0});
    tick();
    drive(LDCT, 1, 0, 0); tick();
    drive(TWB, 1, 0, 2); tick();
    drive(CONT, 0, 1, 0); check_model("twb_pass");
    check("twb_pass_ctl", {9'b0, S, FE, PUP}, {9'b0, 2'b11, 1'b0, 1'b0});
    tick();

    // Reset in the middle of a counted loop.
    drive(LDCT, 1, 0, 0); tick();
    drive(RPCT, 1, 0, 9); tick();
    drive(CONT, 0, 0, 0); tick();
    do_reset("midloop_reset");
    drive(CONT, 0, 1, 0); check_model("restart_jz"); tick();

    // Randomized opcode streams.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rand_reset");
      end else begin
        drive(int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
        check_model("rand");
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
